interboard_send: RTL and testbench

Transmit side of the inter-board link. Accepts one control message per `ctrl_en` pulse from local game control, queues it in a small FIFO, packs the fields into a 24-bit frame and sends it as four 6-bit words over the request/ack 4-phase handshake. It sits directly upstream of the link's bidirectional pad logic. The receiver on the other board rebuilds the `interboard_*` outputs from these words.

---
 rtl/interboard_pkg.sv | 63 ++++++
 rtl/msg_fifo.sv | 66 ++++++
 rtl/interboard_send.sv | 196 +++++++++++++++++++
 tb/tb_interboard_send.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interboard_pkg.sv
// Shared definitions for the inter-board link.
// Frame layout is common to the sender and the receiver.
package interboard_pkg;

  localparam int FRAME_W     = 24;
  localparam int FRAME_WORDS = 4;
  localparam int WORD_W      = 6;
  localparam int IDX_W       = 2;

  localparam int MOVE_DIR_LSB = 0;
  localparam int MOVE_DIR_W   = 1;
  localparam int BLOCK_X_LSB  = 1;
  localparam int BLOCK_X_W    = 5;
  localparam int BLOCK_Y_LSB  = 6;
  localparam int BLOCK_Y_W    = 3;
  localparam int MSG_TYPE_LSB = 9;
  localparam int MSG_TYPE_W   = 4;
  localparam int CARD_LSB     = 13;
  localparam int CARD_W       = 6;
  localparam int SEL_LEN_LSB  = 19;
  localparam int SEL_LEN_W    = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_REQ_HI = 2'd2,
    S_REQ_LO = 2'd3
  } tx_state_e;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic                  move_dir,
    input logic [BLOCK_X_W-1:0]  block_x,
    input logic [BLOCK_Y_W-1:0]  block_y,
    input logic [MSG_TYPE_W-1:0] msg_type,
    input logic [CARD_W-1:0]     card,
    input logic [SEL_LEN_W-1:0]  sel_len
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[MOVE_DIR_LSB +: MOVE_DIR_W] = move_dir;
    f[BLOCK_X_LSB +: BLOCK_X_W]   = block_x;
    f[BLOCK_Y_LSB +: BLOCK_Y_W]   = block_y;
    f[MSG_TYPE_LSB +: MSG_TYPE_W] = msg_type;
    f[CARD_LSB +: CARD_W]         = card;
    f[SEL_LEN_LSB +: SEL_LEN_W]   = sel_len;
    return f;
  endfunction

  function automatic logic [WORD_W-1:0] frame_word(
    input logic [FRAME_W-1:0] f,
    input logic [IDX_W-1:0]   k
  );
    logic [WORD_W-1:0] w;
    unique case (k)
      2'd0:    w = f[5:0];
      2'd1:    w = f[11:6];
      2'd2:    w = f[17:12];
      default: w = f[23:18];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// Synchronous message FIFO with registered count.
// Pushes while full and pops while empty are ignored.
module msg_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/interboard_send.sv
// Inter-board link transmitter: queue, pack, and
// send frames as 6-bit words over a 4-phase handshake.
import interboard_pkg::*;

module interboard_send #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_en,
  input  logic       ctrl_move_dir,
  input  logic [4:0] ctrl_block_x,
  input  logic [2:0] ctrl_block_y,
  input  logic [3:0] ctrl_msg_type,
  input  logic [5:0] ctrl_card,
  input  logic [2:0] ctrl_sel_len,
  input  logic       ack,
  output logic       tx_request,
  output logic [5:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic       err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(FRAME_WORDS - 1);

  tx_state_e          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               req_q, req_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               ack_meta_q, ack_s_q;

  logic               pop;
  logic               push_ok;
  logic [FRAME_W-1:0] push_frame;
  logic [FRAME_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_cnt;

  assign push_frame = pack_frame(
    ctrl_move_dir, ctrl_block_x, ctrl_block_y,
    ctrl_msg_type, ctrl_card, ctrl_sel_len);

  assign push_ok = ctrl_en && !fifo_full;
  assign ovf_d   = ctrl_en && fifo_full;

  msg_fifo #(
    .DEPTH (DEPTH),
    .W     (FRAME_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ctrl_en),
    .pop_i   (pop),
    .wdata_i (push_frame),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // Two-flop synchronizer for the peer's ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // Handshake FSM: next state, word steering, timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    data_d  = data_q;
    req_d   = req_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          frame_d = fifo_rdata;
          idx_d   = '0;
          data_d  = frame_word(fifo_rdata, '0);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        req_d   = 1'b1;
        tmo_d   = '0;
        state_d = S_REQ_HI;
      end
      S_REQ_HI: begin
        if (ack_s_q) begin
          req_d   = 1'b0;
          tmo_d   = '0;
          state_d = S_REQ_LO;
        end else if (tmo_q == TMO_LAST) begin
          req_d   = 1'b0;
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_REQ_LO: begin
        if (!ack_s_q) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            data_d  = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            data_d  = frame_word(frame_q,
                                 idx_q + IDX_W'(1));
            state_d = S_SETUP;
          end
        end else if (tmo_q == TMO_LAST) begin
          req_d   = 1'b0;
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        req_d   = 1'b0;
        data_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Busy reflects the FIFO/FSM state after this edge.
  always_comb begin
    busy_d = push_ok
          || (fifo_cnt > CW'(pop))
          || (state_d != S_IDLE);
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      data_q  <= data_d;
      req_q   <= req_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_request = req_q;
  assign tx_data    = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign err        = err_q;

endmodule

// File: tb/tb_interboard_send.sv
// Directed bench for interboard_send with a small
// peer model that answers the request line.
module tb_interboard_send;

  logic       clk;
  logic       rst;
  logic       ctrl_en;
  logic       ctrl_move_dir;
  logic [4:0] ctrl_block_x;
  logic [2:0] ctrl_block_y;
  logic [3:0] ctrl_msg_type;
  logic [5:0] ctrl_card;
  logic [2:0] ctrl_sel_len;
  logic       ack;
  logic       tx_request;
  logic [5:0] tx_data;
  logic       busy;
  logic       done;
  logic       overflow;
  logic       err;

  int total;
  int bad;
  int done_cnt;
  int err_cnt;
  int ovf_cnt;
  int stab_bad;
  int peer_mode;
  logic [5:0] wq [$];

  interboard_send #(
    .DEPTH   (4),
    .TIMEOUT (20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ctrl_en       (ctrl_en),
    .ctrl_move_dir (ctrl_move_dir),
    .ctrl_block_x  (ctrl_block_x),
    .ctrl_block_y  (ctrl_block_y),
    .ctrl_msg_type (ctrl_msg_type),
    .ctrl_card     (ctrl_card),
    .ctrl_sel_len  (ctrl_sel_len),
    .ack           (ack),
    .tx_request    (tx_request),
    .tx_data       (tx_data),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d",
             total, bad);
    $fatal(1, "watchdog");
  end

  // Peer: mode 0 follows request after a delay,
  // mode 1 never moves ack, mode 2 raises but never drops.
  initial begin : peer
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (ack !== tx_request) begin
        cnt++;
        if (cnt >= 3) begin
          if (peer_mode == 0 ||
              (peer_mode == 2 && tx_request))
            ack = tx_request;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: word capture, stability, pulse counts.
  initial begin : mon
    logic       pr;
    logic [5:0] held;
    pr   = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (done === 1'b1)     done_cnt++;
      if (err === 1'b1)      err_cnt++;
      if (overflow === 1'b1) ovf_cnt++;
      if (tx_request && !pr) begin
        wq.push_back(tx_data);
        held = tx_data;
      end else if (tx_request && tx_data !== held) begin
        stab_bad++;
      end
      pr = tx_request;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic       md,
                      input logic [4:0] x,
                      input logic [2:0] y,
                      input logic [3:0] t,
                      input logic [5:0] c,
                      input logic [2:0] s);
    ctrl_move_dir = md;
    ctrl_block_x  = x;
    ctrl_block_y  = y;
    ctrl_msg_type = t;
    ctrl_card     = c;
    ctrl_sel_len  = s;
    ctrl_en       = 1'b1;
    @(negedge clk);
    ctrl_en = 1'b0;
  endtask

  task automatic wait_done(input string tag,
                           input int target,
                           input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic chk_frame(input string tag,
                           input int base,
                           input logic [5:0] w0,
                           input logic [5:0] w1,
                           input logic [5:0] w2,
                           input logic [5:0] w3);
    logic [5:0]  e [4];
    logic [31:0] o;
    e = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      if (base + i < wq.size()) o = 32'(wq[base + i]);
      else o = 32'hDEAD;
      chk($sformatf("%s_w%0d", tag, i), o, 32'(e[i]));
    end
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, tx_request, tx_data,
            busy, done, overflow, err};
  endfunction

  initial begin : main
    int base;
    int d0;
    int e0;
    int o0;
    int n;
    total = 0; bad = 0;
    done_cnt = 0; err_cnt = 0; ovf_cnt = 0;
    stab_bad = 0; peer_mode = 0;
    rst = 1'b1; ctrl_en = 1'b0; ack = 1'b0;
    ctrl_move_dir = 1'b0; ctrl_block_x = '0;
    ctrl_block_y = '0; ctrl_msg_type = '0;
    ctrl_card = '0; ctrl_sel_len = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs(), 32'd0);

    // Single frame with latency checks.
    send(1'b1, 5'h13, 3'h5, 4'hA, 6'h2C, 3'h6);
    chk("lat_e0_busy", 32'(busy), 32'd1);
    chk("lat_e0_req", 32'(tx_request), 32'd0);
    @(negedge clk);
    chk("lat_e1_data", 32'(tx_data), 32'h27);
    chk("lat_e1_req", 32'(tx_request), 32'd0);
    @(negedge clk);
    chk("lat_e2_req", 32'(tx_request), 32'd1);
    wait_done("single_done", 1, 300);
    chk_frame("single", 0, 6'h27, 6'h15, 6'h19, 6'h0D);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_err", 32'(err_cnt), 32'd0);

    // Queueing with ack stalled behind an in-flight frame.
    peer_mode = 1;
    base = wq.size();
    send(1'b1, 5'h1F, 3'h0, 4'h0, 6'h00, 3'h0);
    n = 0;
    while (!tx_request && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("q_req_up", 32'(tx_request), 32'd1);
    send(1'b0, 5'h01, 3'h0, 4'h0, 6'h00, 3'h0);
    send(1'b0, 5'h02, 3'h0, 4'h0, 6'h00, 3'h0);
    send(1'b0, 5'h03, 3'h0, 4'h0, 6'h00, 3'h0);
    send(1'b0, 5'h04, 3'h0, 4'h0, 6'h00, 3'h0);
    chk("q_ovf_4th", 32'(overflow), 32'd0);
    send(1'b0, 5'h05, 3'h0, 4'h0, 6'h00, 3'h0);
    chk("q_ovf_5th", 32'(overflow), 32'd1);
    peer_mode = 0;
    wait_done("q_done", 6, 2000);
    chk("q_ovf_cnt", 32'(ovf_cnt), 32'd1);
    chk("q_err_cnt", 32'(err_cnt), 32'd0);
    chk_frame("q_p0", base, 6'h3F, 6'h00, 6'h00, 6'h00);
    chk_frame("q_f1", base + 4, 6'h02, 6'h00, 6'h00, 6'h00);
    chk_frame("q_f2", base + 8, 6'h04, 6'h00, 6'h00, 6'h00);
    chk_frame("q_f3", base + 12, 6'h06, 6'h00, 6'h00, 6'h00);
    chk_frame("q_f4", base + 16, 6'h08, 6'h00, 6'h00, 6'h00);
    chk("q_words", 32'(wq.size()), 32'(base + 20));

    // Timeout in REQ_HI, then the next queued frame.
    peer_mode = 1;
    base = wq.size();
    d0 = done_cnt;
    e0 = err_cnt;
    send(1'b0, 5'h07, 3'h0, 4'h0, 6'h00, 3'h0);
    send(1'b0, 5'h09, 3'h0, 4'h0, 6'h00, 3'h0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (err === 1'b1) break;
      if (tx_request === 1'b1) n++;
    end
    chk("to_err_seen", 32'(err), 32'd1);
    chk("to_req_low", 32'(tx_request), 32'd0);
    chk("to_data_zero", 32'(tx_data), 32'd0);
    chk("to_req_window", 32'(n >= 19 && n <= 21), 32'd1);
    peer_mode = 0;
    wait_done("to_next_done", d0 + 1, 400);
    chk("to_err_cnt", 32'(err_cnt), 32'(e0 + 1));
    chk_frame("to_t1", base, 6'h0E,
              6'h12, 6'h00, 6'h00);
    chk_frame("to_t2", base + 1, 6'h12,
              6'h00, 6'h00, 6'h00);

    // Stuck ack: timeout in REQ_LO.
    peer_mode = 2;
    base = wq.size();
    d0 = done_cnt;
    e0 = err_cnt;
    send(1'b1, 5'h00, 3'h0, 4'h0, 6'h00, 3'h0);
    n = 0;
    while (err_cnt == e0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("stuck_err", 32'(err_cnt), 32'(e0 + 1));
    chk("stuck_no_done", 32'(done_cnt), 32'(d0));
    chk("stuck_req", 32'(tx_request), 32'd0);
    chk("stuck_w0", 32'(wq[base]), 32'h01);
    ack = 1'b0;
    peer_mode = 0;
    repeat (4) @(negedge clk);
    chk("stuck_idle", 32'(busy), 32'd0);

    // Reset during word 2 with a second frame queued.
    base = wq.size();
    d0 = done_cnt;
    send(1'b1, 5'h13, 3'h5, 4'hA, 6'h2C, 3'h6);
    send(1'b0, 5'h03, 3'h0, 4'h0, 6'h00, 3'h0);
    n = 0;
    while (wq.size() < base + 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_w2", 32'(wq.size()), 32'(base + 3));
    chk("rst_req_hi", 32'(tx_request), 32'd1);
    chk("rst_w2_data", 32'(tx_data), 32'h19);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outs", outs(), 32'd0);
    rst = 1'b0;
    ack = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_q_lost_busy", 32'(busy), 32'd0);
    chk("rst_q_lost_words", 32'(wq.size()),
        32'(base + 3));
    base = wq.size();
    send(1'b0, 5'h00, 3'h0, 4'h0, 6'h3F, 3'h0);
    wait_done("rst_new_done", d0 + 1, 400);
    chk_frame("rst_new", base, 6'h00, 6'h00, 6'h3E, 6'h01);

    // Push on the same edge as an IDLE pop, count=1.
    base = wq.size();
    d0 = done_cnt;
    o0 = ovf_cnt;
    send(1'b0, 5'h00, 3'h0, 4'h0, 6'h00, 3'h7);
    send(1'b0, 5'h00, 3'h7, 4'hF, 6'h00, 3'h0);
    wait_done("pp_done", d0 + 2, 800);
    chk("pp_no_ovf", 32'(ovf_cnt), 32'(o0));
    chk_frame("pp_a", base, 6'h00, 6'h00, 6'h00, 6'h0E);
    chk_frame("pp_b", base + 4, 6'h00, 6'h3F, 6'h01, 6'h00);

    chk("stable_while_req", 32'(stab_bad), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
